// File: rtl/uart_host_pkg.sv
// Shared types for the CoreUART host-side bus initiator.
package uart_host_pkg;

    // Width of the post-strobe blanking counter (parameters range 1..15).
    localparam int BLANK_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        BLANK = 2'd3
    } state_e;

    // One received byte together with the error flags sampled alongside it.
    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        logic       ovf;
    } rx_word_t;

endpackage

// File: rtl/uart_host_if.sv
// Fabric-side initiator for the CoreUART parallel register interface.
// Turns a valid/ready TX byte stream into write strobes and polls RXRDY to
// feed a valid/ready RX stream (byte plus error flags). All UART strobes and
// U_DATA_IN come straight from flops.
module uart_host_if
    import uart_host_pkg::*;
#(
    parameter int WR_BLANK = 2,
    parameter int RD_BLANK = 2
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] TX_DATA,
    input  logic       TX_VALID,
    output logic       TX_READY,
    output logic [7:0] RX_DATA,
    output logic       RX_PERR,
    output logic       RX_FERR,
    output logic       RX_OVF,
    output logic       RX_VALID,
    input  logic       RX_READY,
    output logic       U_CSN,
    output logic       U_WEN,
    output logic       U_OEN,
    output logic [7:0] U_DATA_IN,
    input  logic [7:0] U_DATA_OUT,
    input  logic       U_TXRDY,
    input  logic       U_RXRDY,
    input  logic       U_PARITY_ERR,
    input  logic       U_FRAMING_ERR,
    input  logic       U_OVERFLOW
);

    localparam logic [BLANK_W-1:0] WR_LD = BLANK_W'(WR_BLANK);
    localparam logic [BLANK_W-1:0] RD_LD = BLANK_W'(RD_BLANK);

    state_e               state_q, state_d;
    logic [BLANK_W-1:0]   blank_q, blank_d;
    logic                 csn_q, csn_d;
    logic                 wen_q, wen_d;
    logic                 oen_q, oen_d;
    logic [7:0]           din_q, din_d;
    rx_word_t             rx_q, rx_d;
    logic                 rxv_q, rxv_d;

    logic slot_free, rd_req, wr_ok;

    // Eligibility: reads win over writes, and both wait out the blank window
    // so a stale TXRDY/RXRDY from the core is never acted upon.
    always_comb begin
        slot_free = !rxv_q || RX_READY;
        rd_req    = U_RXRDY && slot_free && (blank_q == '0);
        wr_ok     = U_TXRDY && (blank_q == '0) && !rd_req;
        TX_READY  = (state_q == IDLE) && wr_ok && !RESET;
    end

    // Next-state, next-strobe and RX slot update.
    always_comb begin
        state_d = state_q;
        blank_d = blank_q;
        csn_d   = 1'b1;
        wen_d   = 1'b1;
        oen_d   = 1'b1;
        din_d   = din_q;
        rx_d    = rx_q;
        rxv_d   = rxv_q && !RX_READY;
        case (state_q)
            IDLE: begin
                if (rd_req) begin
                    state_d = READ;
                    csn_d   = 1'b0;
                    oen_d   = 1'b0;
                end else if (TX_VALID && TX_READY) begin
                    state_d = WRITE;
                    din_d   = TX_DATA;
                    csn_d   = 1'b0;
                    wen_d   = 1'b0;
                end
            end
            WRITE: begin
                blank_d = WR_LD;
                state_d = BLANK;
            end
            READ: begin
                // Sample at the edge that closes the one-cycle read strobe.
                rx_d.data = U_DATA_OUT;
                rx_d.perr = U_PARITY_ERR;
                rx_d.ferr = U_FRAMING_ERR;
                rx_d.ovf  = U_OVERFLOW;
                rxv_d     = 1'b1;
                blank_d   = RD_LD;
                state_d   = BLANK;
            end
            BLANK: begin
                blank_d = (blank_q == '0) ? '0 : blank_q - 1'b1;
                if (blank_q <= 1) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counter, registered strobes and RX slot.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            blank_q <= '0;
            csn_q   <= 1'b1;
            wen_q   <= 1'b1;
            oen_q   <= 1'b1;
            din_q   <= '0;
            rx_q    <= '0;
            rxv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            blank_q <= blank_d;
            csn_q   <= csn_d;
            wen_q   <= wen_d;
            oen_q   <= oen_d;
            din_q   <= din_d;
            rx_q    <= rx_d;
            rxv_q   <= rxv_d;
        end
    end

    assign U_CSN     = csn_q;
    assign U_WEN     = wen_q;
    assign U_OEN     = oen_q;
    assign U_DATA_IN = din_q;
    assign RX_DATA   = rx_q.data;
    assign RX_PERR   = rx_q.perr;
    assign RX_FERR   = rx_q.ferr;
    assign RX_OVF    = rx_q.ovf;
    assign RX_VALID  = rxv_q;

endmodule

// File: tb/tb_uart_host_if.sv
// Directed bench for uart_host_if: per-cycle vector table plus a few
// multi-cycle sequences (backpressure, TX burst with stall, reset in READ).
module tb_uart_host_if;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [7:0] TX_DATA;
    logic       TX_VALID;
    logic       TX_READY;
    logic [7:0] RX_DATA;
    logic       RX_PERR, RX_FERR, RX_OVF;
    logic       RX_VALID;
    logic       RX_READY;
    logic       U_CSN, U_WEN, U_OEN;
    logic [7:0] U_DATA_IN;
    logic [7:0] U_DATA_OUT;
    logic       U_TXRDY, U_RXRDY;
    logic       U_PARITY_ERR, U_FRAMING_ERR, U_OVERFLOW;

    int total = 0;
    int bad   = 0;
    logic [7:0] wr_log[$];
    logic [7:0] rx_log[$];

    always #5 CLK = ~CLK;

    uart_host_if #(.WR_BLANK(2), .RD_BLANK(2)) dut (
        .CLK(CLK), .RESET(RESET),
        .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY),
        .RX_DATA(RX_DATA), .RX_PERR(RX_PERR), .RX_FERR(RX_FERR), .RX_OVF(RX_OVF),
        .RX_VALID(RX_VALID), .RX_READY(RX_READY),
        .U_CSN(U_CSN), .U_WEN(U_WEN), .U_OEN(U_OEN),
        .U_DATA_IN(U_DATA_IN), .U_DATA_OUT(U_DATA_OUT),
        .U_TXRDY(U_TXRDY), .U_RXRDY(U_RXRDY),
        .U_PARITY_ERR(U_PARITY_ERR), .U_FRAMING_ERR(U_FRAMING_ERR),
        .U_OVERFLOW(U_OVERFLOW)
    );

    // Log write strobes and RX handshakes as the edge sees them.
    always @(posedge CLK) begin
        if (!U_CSN && !U_WEN) wr_log.push_back(U_DATA_IN);
        if (RX_VALID && RX_READY) rx_log.push_back(RX_DATA);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic       rst;
        logic       txv;
        logic [7:0] txd;
        logic       txrdy;
        logic       rxrdy;
        logic [7:0] dout;
        logic [2:0] err;      // {parity, framing, overflow}
        logic       rxready;
        logic [23:0] exp;     // {TX_READY,CSN,WEN,OEN,DATA_IN,RX_VALID,RX_DATA,PERR,FERR,OVF}
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic rst, input logic txv, input logic [7:0] txd, input logic txrdy,
        input logic rxrdy, input logic [7:0] dout, input logic [2:0] err, input logic rxready,
        input logic txr, input logic csn, input logic wen, input logic oen,
        input logic [7:0] din, input logic rxv, input logic [7:0] rxd, input logic [2:0] fl);
        vec_t v;
        v.rst = rst; v.txv = txv; v.txd = txd; v.txrdy = txrdy;
        v.rxrdy = rxrdy; v.dout = dout; v.err = err; v.rxready = rxready;
        v.exp = {txr, csn, wen, oen, din, rxv, rxd, fl};
        return v;
    endfunction

    function automatic logic [23:0] obs();
        return {TX_READY, U_CSN, U_WEN, U_OEN, U_DATA_IN, RX_VALID, RX_DATA,
                RX_PERR, RX_FERR, RX_OVF};
    endfunction

    task automatic send(input logic [7:0] b);
        bit done = 0;
        @(negedge CLK);
        TX_DATA  = b;
        TX_VALID = 1'b1;
        for (int n = 0; n < 40 && !done; n++) begin
            #1;
            if (TX_READY) begin
                @(posedge CLK);
                #1;
                TX_VALID = 1'b0;
                done = 1;
            end else begin
                @(negedge CLK);
            end
        end
        chk("send_handshake", 32'(done), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got, ok, found;

        RESET = 1; TX_DATA = 0; TX_VALID = 0; RX_READY = 0; U_DATA_OUT = 0;
        U_TXRDY = 0; U_RXRDY = 0; U_PARITY_ERR = 0; U_FRAMING_ERR = 0; U_OVERFLOW = 0;
        repeat (3) @(posedge CLK);

        //          rst txv txd    txr rxr dout   err   rdy | TXR CSN WEN OEN DIN   RXV RXD   FL
        vecs.push_back(mk(1, 1, 8'hA5, 1, 0, 8'h00, 3'd0, 0,  0, 1, 1, 1, 8'h00, 0, 8'h00, 3'd0)); // reset
        vecs.push_back(mk(0, 1, 8'hA5, 1, 0, 8'h00, 3'd0, 0,  1, 1, 1, 1, 8'h00, 0, 8'h00, 3'd0)); // accept A5
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 8'h00, 3'd0, 0,  0, 0, 0, 1, 8'hA5, 0, 8'h00, 3'd0)); // write strobe
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 8'h00, 3'd0, 0,  0, 1, 1, 1, 8'hA5, 0, 8'h00, 3'd0)); // blank
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 8'h00, 3'd0, 0,  0, 1, 1, 1, 8'hA5, 0, 8'h00, 3'd0)); // blank
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 8'h00, 3'd0, 0,  1, 1, 1, 1, 8'hA5, 0, 8'h00, 3'd0)); // idle, ready w/o valid
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 8'h00, 3'd0, 0,  0, 1, 1, 1, 8'hA5, 0, 8'h00, 3'd0)); // TXRDY low
        vecs.push_back(mk(0, 1, 8'h55, 1, 1, 8'h3C, 3'd4, 0,  0, 1, 1, 1, 8'hA5, 0, 8'h00, 3'd0)); // read beats write
        vecs.push_back(mk(0, 1, 8'h55, 1, 1, 8'h3C, 3'd4, 0,  0, 0, 1, 0, 8'hA5, 0, 8'h00, 3'd0)); // read strobe
        vecs.push_back(mk(0, 1, 8'h55, 1, 0, 8'h00, 3'd0, 0,  0, 1, 1, 1, 8'hA5, 1, 8'h3C, 3'd4)); // captured
        vecs.push_back(mk(0, 1, 8'h55, 1, 0, 8'h00, 3'd0, 0,  0, 1, 1, 1, 8'hA5, 1, 8'h3C, 3'd4)); // blank
        vecs.push_back(mk(0, 1, 8'h55, 1, 0, 8'h00, 3'd0, 0,  1, 1, 1, 1, 8'hA5, 1, 8'h3C, 3'd4)); // accept 55
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 8'h00, 3'd0, 0,  0, 0, 0, 1, 8'h55, 1, 8'h3C, 3'd4)); // write strobe
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 8'h00, 3'd0, 1,  0, 1, 1, 1, 8'h55, 1, 8'h3C, 3'd4)); // consume
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 8'h00, 3'd0, 0,  0, 1, 1, 1, 8'h55, 0, 8'h3C, 3'd4)); // slot empty
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 8'h00, 3'd0, 0,  1, 1, 1, 1, 8'h55, 0, 8'h3C, 3'd4)); // idle
        vecs.push_back(mk(0, 0, 8'h00, 1, 1, 8'hC3, 3'd3, 0,  0, 1, 1, 1, 8'h55, 0, 8'h3C, 3'd4)); // rd_req
        vecs.push_back(mk(0, 0, 8'h00, 1, 1, 8'hC3, 3'd3, 0,  0, 0, 1, 0, 8'h55, 0, 8'h3C, 3'd4)); // read strobe
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 8'h00, 3'd0, 0,  0, 1, 1, 1, 8'h55, 1, 8'hC3, 3'd3)); // ferr+ovf
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 8'h00, 3'd0, 0,  0, 1, 1, 1, 8'h55, 1, 8'hC3, 3'd3)); // blank
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 8'h00, 3'd0, 1,  1, 1, 1, 1, 8'h55, 1, 8'hC3, 3'd3)); // consume
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 8'h00, 3'd0, 0,  1, 1, 1, 1, 8'h55, 0, 8'hC3, 3'd3)); // empty

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge CLK);
            RESET = vecs[i].rst; TX_VALID = vecs[i].txv; TX_DATA = vecs[i].txd;
            U_TXRDY = vecs[i].txrdy; U_RXRDY = vecs[i].rxrdy; U_DATA_OUT = vecs[i].dout;
            {U_PARITY_ERR, U_FRAMING_ERR, U_OVERFLOW} = vecs[i].err;
            RX_READY = vecs[i].rxready;
            #1;
            chk($sformatf("vec%0d", i), 32'(obs()), 32'(vecs[i].exp));
        end

        // Backpressure: full slot blocks reads; releasing it reads promptly.
        @(negedge CLK);
        TX_VALID = 0; U_TXRDY = 0; RX_READY = 0;
        {U_PARITY_ERR, U_FRAMING_ERR, U_OVERFLOW} = 3'b000;
        U_DATA_OUT = 8'h11; U_RXRDY = 1;
        rx_log.delete();
        got = 0;
        for (int n = 0; n < 10 && !got; n++) begin
            @(negedge CLK); #1;
            if (RX_VALID) got = 1;
        end
        chk("bp_first_valid", 32'(got), 32'd1);
        U_DATA_OUT = 8'h22;
        ok = 1;
        repeat (8) begin
            @(negedge CLK); #1;
            if (!U_OEN) ok = 0;
        end
        chk("bp_no_read", 32'(ok), 32'd1);
        chk("bp_hold_data", 32'(RX_DATA), 32'h11);
        @(negedge CLK);
        RX_READY = 1;
        found = 0;
        for (int n = 1; n <= 2 && !found; n++) begin
            @(negedge CLK); #1;
            if (!U_OEN) found = 1;
        end
        chk("bp_read_latency", 32'(found), 32'd1);
        U_RXRDY = 0;
        repeat (5) @(negedge CLK);
        RX_READY = 0;
        chk("bp_rx_count", 32'(rx_log.size()), 32'd2);
        if (rx_log.size() == 2) begin
            chk("bp_rx0", 32'(rx_log[0]), 32'h11);
            chk("bp_rx1", 32'(rx_log[1]), 32'h22);
        end

        // Burst of four bytes with TXRDY held low after the second write.
        U_TXRDY = 1;
        wr_log.delete();
        send(8'h01);
        send(8'h02);
        U_TXRDY = 0;
        TX_DATA = 8'h03; TX_VALID = 1;
        ok = 1;
        repeat (10) begin
            @(negedge CLK); #1;
            if (TX_READY) ok = 0;
        end
        chk("stall_no_ready", 32'(ok), 32'd1);
        chk("stall_wr_count", 32'(wr_log.size()), 32'd2);
        TX_VALID = 0;
        U_TXRDY = 1;
        send(8'h03);
        send(8'h04);
        repeat (6) @(negedge CLK);
        chk("burst_wr_count", 32'(wr_log.size()), 32'd4);
        if (wr_log.size() == 4)
            for (int i = 0; i < 4; i++)
                chk($sformatf("burst_wr%0d", i), 32'(wr_log[i]), 32'(i + 1));

        // Reset asserted during the READ strobe cycle.
        @(negedge CLK);
        RX_READY = 1; U_DATA_OUT = 8'h99; U_RXRDY = 1;
        found = 0;
        for (int n = 0; n < 4 && !found; n++) begin
            @(negedge CLK); #1;
            if (!U_OEN) found = 1;
        end
        chk("rst_reach_read", 32'(found), 32'd1);
        RESET = 1; U_RXRDY = 0;
        @(negedge CLK); #1;
        chk("rst_strobes", 32'({U_CSN, U_WEN, U_OEN}), 32'b111);
        chk("rst_rx_valid", 32'(RX_VALID), 32'd0);
        chk("rst_rx_data", 32'(RX_DATA), 32'h00);
        chk("rst_tx_ready", 32'(TX_READY), 32'd0);
        RESET = 0;
        #1;
        chk("rst_idle_ready", 32'(TX_READY), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
